// File: rtl/vx_dvg_stack_unit.sv
// Per-warp SIMT divergence stack: splits push reconvergence/else entries, joins
// walk them back. Optional sticky overflow/underflow flags under DVG_STACK_ERR_EN.
module vx_dvg_stack_unit #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 30,
  parameter int DEPTH       = 8,
  localparam int NWW  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int PTRW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NWW-1:0]         req_wid,
  input  logic                   req_split,
  input  logic                   req_join,
  input  logic                   split_is_dvg,
  input  logic [NUM_THREADS-1:0] then_tmask,
  input  logic [NUM_THREADS-1:0] else_tmask,
  input  logic [PC_BITS-1:0]     next_pc,
  input  logic [PTRW-1:0]        join_ptr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_is_dvg,
  output logic                   out_is_else,
  output logic [NWW-1:0]         out_wid,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [PC_BITS-1:0]     out_pc,
  input  logic [NWW-1:0]         stack_wid,
  output logic [PTRW-1:0]        stack_ptr,
  output logic [NUM_WARPS-1:0]   stack_full,
  output logic [NUM_WARPS-1:0]   stack_empty,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTRW-1:0] DEPTH_P = PTRW'(DEPTH);

  logic [PTRW-1:0]        ptr_r        [NUM_WARPS];
  logic [DEPTH-1:0]       pend_r       [NUM_WARPS];
  logic [NUM_THREADS-1:0] reconv_mem_r [NUM_WARPS][DEPTH];
  logic [NUM_THREADS-1:0] else_mem_r   [NUM_WARPS][DEPTH];
  logic [PC_BITS-1:0]     pc_mem_r     [NUM_WARPS][DEPTH];

  logic                   out_valid_r;
  logic                   out_is_dvg_r;
  logic                   out_is_else_r;
  logic [NWW-1:0]         out_wid_r;
  logic [NUM_THREADS-1:0] out_tmask_r;
  logic [PC_BITS-1:0]     out_pc_r;

  logic                   req_ready_s;
  logic                   accept_s;
  logic                   wid_ok_s;
  logic [PTRW-1:0]        cur_ptr_s;
  logic [SW-1:0]          top_idx_s;
  logic [SW-1:0]          push_idx_s;
  logic                   is_full_s;
  logic                   is_empty_s;
  logic                   do_split_s;
  logic                   push_s;
  logic                   do_join_s;
  logic                   join_dvg_s;
  logic                   pop_else_s;
  logic                   pop_s;
  logic                   top_pend_s;
  logic [NUM_THREADS-1:0] top_reconv_s;
  logic [NUM_THREADS-1:0] top_else_s;
  logic [PC_BITS-1:0]     top_pc_s;
  logic                   nxt_dvg_s;
  logic                   nxt_else_s;
  logic [NUM_THREADS-1:0] nxt_tmask_s;
  logic [PC_BITS-1:0]     nxt_pc_s;

  assign req_ready_s = !out_valid_r || out_ready;
  assign accept_s    = req_valid && req_ready_s;
  assign wid_ok_s    = (int'(req_wid) < NUM_WARPS);
  assign cur_ptr_s   = wid_ok_s ? ptr_r[req_wid] : '0;
  assign top_idx_s   = SW'(cur_ptr_s - PTRW'(1));
  assign push_idx_s  = SW'(cur_ptr_s);
  assign is_full_s   = (cur_ptr_s == DEPTH_P);
  assign is_empty_s  = (cur_ptr_s == '0);

  // A request carrying both split and join is treated as a split only.
  assign do_split_s  = accept_s && req_split && split_is_dvg && wid_ok_s;
  assign push_s      = do_split_s && !is_full_s;
  assign do_join_s   = accept_s && !req_split && req_join;
  assign join_dvg_s  = (join_ptr != cur_ptr_s);
  assign pop_else_s  = do_join_s && join_dvg_s && !is_empty_s && top_pend_s;
  assign pop_s       = do_join_s && join_dvg_s && !is_empty_s && !top_pend_s;

  // Read the addressed warp's top-of-stack entry.
  always_comb begin
    top_pend_s   = 1'b0;
    top_reconv_s = '0;
    top_else_s   = '0;
    top_pc_s     = '0;
    if (wid_ok_s) begin
      top_pend_s   = pend_r[req_wid][top_idx_s];
      top_reconv_s = reconv_mem_r[req_wid][top_idx_s];
      top_else_s   = else_mem_r[req_wid][top_idx_s];
      top_pc_s     = pc_mem_r[req_wid][top_idx_s];
    end else begin
      top_pend_s   = 1'b0;
    end
  end

  // Form the join result: else path first, then reconvergence, empty gives zeros.
  always_comb begin
    nxt_dvg_s   = 1'b0;
    nxt_else_s  = 1'b0;
    nxt_tmask_s = '0;
    nxt_pc_s    = '0;
    if (join_dvg_s) begin
      nxt_dvg_s = 1'b1;
      if (is_empty_s) begin
        nxt_tmask_s = '0;
      end else if (top_pend_s) begin
        nxt_else_s  = 1'b1;
        nxt_tmask_s = top_else_s;
        nxt_pc_s    = top_pc_s;
      end else begin
        nxt_tmask_s = top_reconv_s;
      end
    end else begin
      nxt_dvg_s = 1'b0;
    end
  end

  // Stack pointers and else-pending bits; pointers move in the acceptance cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        ptr_r[w]  <= '0;
        pend_r[w] <= '0;
      end
    end else if (push_s) begin
      ptr_r[req_wid]             <= cur_ptr_s + PTRW'(1);
      pend_r[req_wid][push_idx_s] <= 1'b1;
    end else if (pop_else_s) begin
      pend_r[req_wid][top_idx_s] <= 1'b0;
    end else if (pop_s) begin
      ptr_r[req_wid] <= cur_ptr_s - PTRW'(1);
    end
  end

  // Slot payloads carry no reset; they are only read below a valid pointer.
  always_ff @(posedge clk) begin
    if (push_s) begin
      reconv_mem_r[req_wid][push_idx_s] <= then_tmask | else_tmask;
      else_mem_r[req_wid][push_idx_s]   <= else_tmask;
      pc_mem_r[req_wid][push_idx_s]     <= next_pc;
    end
  end

  // Join result register, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r   <= 1'b0;
      out_is_dvg_r  <= 1'b0;
      out_is_else_r <= 1'b0;
      out_wid_r     <= '0;
      out_tmask_r   <= '0;
      out_pc_r      <= '0;
    end else if (do_join_s) begin
      out_valid_r   <= 1'b1;
      out_is_dvg_r  <= nxt_dvg_s;
      out_is_else_r <= nxt_else_s;
      out_wid_r     <= req_wid;
      out_tmask_r   <= nxt_tmask_s;
      out_pc_r      <= nxt_pc_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Per-warp status and the pointer query port.
  always_comb begin
    stack_full  = '0;
    stack_empty = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      stack_full[w]  = (ptr_r[w] == DEPTH_P);
      stack_empty[w] = (ptr_r[w] == '0);
    end
    if (int'(stack_wid) < NUM_WARPS) begin
      stack_ptr = ptr_r[stack_wid];
    end else begin
      stack_ptr = '0;
    end
  end

`ifdef DVG_STACK_ERR_EN
  logic ovf_s;
  logic unf_s;
  logic err_ovf_r;
  logic err_unf_r;

  assign ovf_s = do_split_s && is_full_s;
  assign unf_s = do_join_s && join_dvg_s && is_empty_s;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      if (ovf_s) err_ovf_r <= 1'b1;
      if (unf_s) err_unf_r <= 1'b1;
    end
  end

  assign err_overflow  = err_ovf_r;
  assign err_underflow = err_unf_r;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  assign req_ready   = req_ready_s;
  assign out_valid   = out_valid_r;
  assign out_is_dvg  = out_is_dvg_r;
  assign out_is_else = out_is_else_r;
  assign out_wid     = out_wid_r;
  assign out_tmask   = out_tmask_r;
  assign out_pc      = out_pc_r;

endmodule
